// File: rtl/jk_drive_sequencer.sv
// jk_drive_sequencer
// Queues hold/reset/set/toggle commands and replays each one onto a JK latch
// as J/K setup, a bounded enable pulse and J/K hold. A shadow model of the
// latch Q is kept and compared with the latch feedback at the end of every
// command; any disagreement raises a sticky mismatch flag.
module jk_drive_sequencer #(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned SETUP_CYCLES = 1,
    parameter int unsigned PULSE_CYCLES = 1,
    parameter int unsigned HOLD_CYCLES  = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cmd_valid,
    input  logic [1:0]             cmd,
    output logic                   cmd_ready,
    output logic                   J,
    output logic                   K,
    output logic                   enable,
    input  logic                   q_in,
    output logic                   q_expected,
    output logic                   q_known,
    output logic                   mismatch,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] level
);

    // ------------------------------------------------------------------
    // Derived sizes
    // ------------------------------------------------------------------
    localparam int unsigned AW      = $clog2(DEPTH);
    localparam int unsigned LW      = AW + 1;
    localparam int unsigned MAX_SP  = (SETUP_CYCLES > PULSE_CYCLES) ? SETUP_CYCLES
                                                                    : PULSE_CYCLES;
    localparam int unsigned MAX_CYC = (MAX_SP > HOLD_CYCLES) ? MAX_SP : HOLD_CYCLES;
    localparam int unsigned CW      = $clog2(MAX_CYC + 1);

    localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_CYCLES - 1);
    localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYCLES - 1);
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

    // FSM encoding
    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_SETUP = 2'b01;
    localparam logic [1:0] ST_PULSE = 2'b10;
    localparam logic [1:0] ST_HOLD  = 2'b11;

    // Command encoding; the two bits are exactly {J, K}
    localparam logic [1:0] CMD_HOLD   = 2'b00;
    localparam logic [1:0] CMD_RESET  = 2'b01;
    localparam logic [1:0] CMD_SET    = 2'b10;
    localparam logic [1:0] CMD_TOGGLE = 2'b11;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [LW-1:0] level_q;
    logic [LW-1:0] level_d;
    logic          ready_q;
    logic          nonempty_q;

    logic [1:0]    state_q;
    logic [1:0]    state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    logic          j_q;
    logic          k_q;
    logic          en_q;
    logic          qe_q;
    logic          qk_q;
    logic          mis_q;
    logic          busy_q;

    // ------------------------------------------------------------------
    // Control strobes
    // ------------------------------------------------------------------
    logic       push;
    logic       pop;
    logic       load_jk;
    logic       clear_jk;
    logic       enter_pulse;
    logic       leave_pulse;
    logic       do_check;
    logic [1:0] head_cmd;
    logic [1:0] cur_cmd;
    logic       fifo_nonempty;

    // Readiness comes from the registered level, so a full FIFO refuses a
    // push even on the edge where it also pops.
    assign push          = cmd_valid & ready_q;
    assign head_cmd      = mem_q[rd_ptr_q];
    assign cur_cmd       = {j_q, k_q};
    assign fifo_nonempty = (level_q != '0);

    // Sequencing FSM: decides pops, J/K loads and enable edges
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pop         = 1'b0;
        load_jk     = 1'b0;
        clear_jk    = 1'b0;
        enter_pulse = 1'b0;
        leave_pulse = 1'b0;
        do_check    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // A freshly written entry becomes poppable one cycle after it
                // lands, giving a fixed two-edge accept-to-drive latency.
                if (fifo_nonempty && nonempty_q) begin
                    pop     = 1'b1;
                    load_jk = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_SETUP;
                end
            end

            ST_SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    enter_pulse = 1'b1;
                    cnt_d       = '0;
                    state_d     = ST_PULSE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            ST_PULSE: begin
                if (cnt_q == PULSE_LAST) begin
                    leave_pulse = 1'b1;
                    cnt_d       = '0;
                    state_d     = ST_HOLD;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            ST_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    do_check = 1'b1;
                    cnt_d    = '0;
                    // Back-to-back commands skip IDLE entirely
                    if (fifo_nonempty) begin
                        pop     = 1'b1;
                        load_jk = 1'b1;
                        state_d = ST_SETUP;
                    end else begin
                        clear_jk = 1'b1;
                        state_d  = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // FIFO occupancy next state
    always_comb begin
        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------

    // Command storage; contents are don't-care once the pointers reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= cmd;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
        end
    end

    // Occupancy, ready flag and delayed non-empty flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q    <= '0;
            ready_q    <= 1'b0;
            nonempty_q <= 1'b0;
        end else begin
            level_q    <= level_d;
            ready_q    <= (level_d < FULL_LEVEL);
            nonempty_q <= fifo_nonempty;
        end
    end

    // ------------------------------------------------------------------
    // Sequencer registers
    // ------------------------------------------------------------------

    // FSM state and phase counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= (state_d != ST_IDLE);
        end
    end

    // J/K drive: changes only when a command is loaded or the queue drains
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            j_q <= 1'b0;
            k_q <= 1'b0;
        end else if (load_jk) begin
            j_q <= head_cmd[1];
            k_q <= head_cmd[0];
        end else if (clear_jk) begin
            j_q <= 1'b0;
            k_q <= 1'b0;
        end
    end

    // Enable pulse; the async reset drops it mid-pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q <= 1'b0;
        end else if (enter_pulse) begin
            en_q <= 1'b1;
        end else if (leave_pulse) begin
            en_q <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Latch model and checker
    // ------------------------------------------------------------------

    // Shadow Q, updated when the enable pulse starts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qe_q <= 1'b0;
            qk_q <= 1'b0;
        end else if (enter_pulse) begin
            unique case (cur_cmd)
                CMD_RESET: begin
                    qe_q <= 1'b0;
                    qk_q <= 1'b1;
                end
                CMD_SET: begin
                    qe_q <= 1'b1;
                    qk_q <= 1'b1;
                end
                // Toggle of an unknown Q stays unknown
                CMD_TOGGLE: begin
                    qe_q <= ~qe_q;
                end
                CMD_HOLD: begin
                    qe_q <= qe_q;
                end
            endcase
        end
    end

    // Sticky mismatch, sampled only on the edge that leaves HOLD
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mis_q <= 1'b0;
        end else if (do_check && qk_q && (q_in != qe_q)) begin
            mis_q <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign cmd_ready  = ready_q;
    assign J          = j_q;
    assign K          = k_q;
    assign enable     = en_q;
    assign q_expected = qe_q;
    assign q_known    = qk_q;
    assign mismatch   = mis_q;
    assign busy       = busy_q;
    assign level      = level_q;

endmodule
